// File: rtl/stack_arbiter.sv
// Round-robin arbiter serialising push/pop requests from NREQ requesters onto one external stack.
// Optional statistics counters are enabled by defining STACK_ARBITER_STATS_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for any request; grant the round-robin winner
// ST_ISSUE | strobe the stack (or flag an error on full/empty)
// ST_RESP  | return the completion to the winner, advance rr pointer
module stack_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic                  rsp_err,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [WIDTH-1:0]      stk_data_in,
    input  logic [WIDTH-1:0]      stk_data_out,
    input  logic                  stk_empty,
    input  logic                  stk_full
`ifdef STACK_ARBITER_STATS_EN
    ,
    output logic [15:0]           stat_push,
    output logic [15:0]           stat_pop,
    output logic [15:0]           stat_err
`endif
);

    localparam int                PTR_W   = $clog2(NREQ);
    localparam logic [PTR_W:0]    NREQ_C  = (PTR_W+1)'(NREQ);
    localparam logic [PTR_W-1:0]  LAST_C  = PTR_W'(NREQ-1);
    localparam logic [NREQ-1:0]   ONE_C   = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_win;
    logic               r_op;
    logic [WIDTH-1:0]   r_data;
    logic               r_err;
    logic [WIDTH-1:0]   r_rsp_data;

    logic               w_any;
    logic               w_found;
    logic [PTR_W:0]     w_cand;
    logic [PTR_W-1:0]   w_winner;
    logic               w_push_ok;
    logic               w_pop_ok;

    // Search upward from the round-robin pointer, wrapping modulo NREQ.
    always_comb begin
        w_any    = |req_valid;
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_cand >= NREQ_C) begin
                w_cand = w_cand - NREQ_C;
            end
            if (!w_found && req_valid[w_cand[PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[PTR_W-1:0];
            end
        end
    end

    assign w_push_ok = r_op & ~stk_full;
    assign w_pop_ok  = ~r_op & ~stk_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_err     = 1'b0;
        rsp_data    = '0;
        busy        = (r_state != ST_IDLE);
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_data_in = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) req_ready = ONE_C << w_winner;
            end
            ST_ISSUE: begin
                stk_push    = w_push_ok;
                stk_pop     = w_pop_ok;
                stk_data_in = w_push_ok ? r_data : '0;
            end
            ST_RESP: begin
                rsp_valid = ONE_C << r_win;
                rsp_err   = r_err;
                rsp_data  = r_rsp_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_win      <= '0;
            r_op       <= 1'b0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win  <= w_winner;
                        r_op   <= req_op[w_winner];
                        r_data <= req_data[w_winner*WIDTH +: WIDTH];
                    end
                end
                ST_ISSUE: begin
                    r_err      <= ~(w_push_ok | w_pop_ok);
                    r_rsp_data <= w_pop_ok ? stk_data_out : '0;
                end
                ST_RESP: begin
                    r_rr_ptr <= (r_win == LAST_C) ? '0 : r_win + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef STACK_ARBITER_STATS_EN
    logic [15:0] r_stat_push;
    logic [15:0] r_stat_pop;
    logic [15:0] r_stat_err;

    // Counters saturate rather than wrap so a long-running count never looks small.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_push <= '0;
            r_stat_pop  <= '0;
            r_stat_err  <= '0;
        end else if (r_state == ST_RESP) begin
            if (r_err) begin
                if (r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
            end else if (r_op) begin
                if (r_stat_push != 16'hFFFF) r_stat_push <= r_stat_push + 16'd1;
            end else begin
                if (r_stat_pop != 16'hFFFF) r_stat_pop <= r_stat_pop + 16'd1;
            end
        end
    end

    assign stat_push = r_stat_push;
    assign stat_pop  = r_stat_pop;
    assign stat_err  = r_stat_err;
`endif

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a depth-2 behavioural stack and a response scoreboard.
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic       rsp_err;
    logic [3:0] rsp_data;
    logic       busy;
    logic       stk_push;
    logic       stk_pop;
    logic [3:0] stk_data_in;
    logic [3:0] stk_data_out;
    logic       stk_empty;
    logic       stk_full;
`ifdef STACK_ARBITER_STATS_EN
    logic [15:0] stat_push;
    logic [15:0] stat_pop;
    logic [15:0] stat_err;
`endif

    stack_arbiter #(.WIDTH(4), .NREQ(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .stk_push     (stk_push),
        .stk_pop      (stk_pop),
        .stk_data_in  (stk_data_in),
        .stk_data_out (stk_data_out),
        .stk_empty    (stk_empty),
        .stk_full     (stk_full)
`ifdef STACK_ARBITER_STATS_EN
        ,
        .stat_push    (stat_push),
        .stat_pop     (stat_pop),
        .stat_err     (stat_err)
`endif
    );

    always #5 clk = ~clk;

    // Depth-2 stack with registered occupancy, reset by the same rst.
    logic [3:0] stk_mem [4];
    logic [1:0] stk_cnt;
    always @(posedge clk) begin
        if (rst) begin
            stk_cnt <= 2'd0;
        end else if (stk_push && stk_cnt < 2'd2) begin
            stk_mem[stk_cnt] <= stk_data_in;
            stk_cnt <= stk_cnt + 2'd1;
        end else if (stk_pop && stk_cnt > 2'd0) begin
            stk_cnt <= stk_cnt - 2'd1;
        end
    end
    assign stk_empty    = (stk_cnt == 2'd0);
    assign stk_full     = (stk_cnt == 2'd2);
    assign stk_data_out = (stk_cnt > 2'd0) ? stk_mem[stk_cnt - 2'd1] : 4'h0;

    typedef struct {
        int         idx;
        logic       err;
        logic [3:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] oh(input int i);
        logic [1:0] one;
        one = 2'b01;
        return one << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        req_op    = 2'b00;
        req_data  = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_resp(input string tag);
        exp_t x;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_rsp"}, {14'd0, rsp_valid}, 16'd0);
        end else begin
            x = exp_q.pop_front();
            chk({tag, "_rsp_valid"}, {14'd0, rsp_valid}, {14'd0, oh(x.idx)});
            chk({tag, "_rsp_err"},   {15'd0, rsp_err},   {15'd0, x.err});
            chk({tag, "_rsp_data"},  {12'd0, rsp_data},  {12'd0, x.data});
        end
    endtask

    // One isolated request: grant at T, stack strobe at T+1, response at T+2.
    task automatic do_op(input string tag, input int idx, input logic op,
                         input logic [3:0] d, input logic e_err, input logic [3:0] e_data);
        exp_t x;
        int   n;
        logic e_push;
        logic e_pop;
        req_valid[idx]        = 1'b1;
        req_op[idx]           = op;
        req_data[idx*4 +: 4]  = d;
        #1;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_grant"}, {14'd0, req_ready}, {14'd0, oh(idx)});
        if (req_ready == 2'b00) begin
            req_valid[idx] = 1'b0;
            return;
        end
        x.idx  = idx;
        x.err  = e_err;
        x.data = e_data;
        exp_q.push_back(x);
        tick();
        req_valid[idx] = 1'b0;
        e_push = op & ~e_err;
        e_pop  = ~op & ~e_err;
        chk({tag, "_busy"},     {15'd0, busy},        16'd1);
        chk({tag, "_push"},     {15'd0, stk_push},    {15'd0, e_push});
        chk({tag, "_pop"},      {15'd0, stk_pop},     {15'd0, e_pop});
        chk({tag, "_data_in"},  {12'd0, stk_data_in}, e_push ? {12'd0, d} : 16'd0);
        tick();
        check_resp(tag);
        tick();
        chk({tag, "_idle"}, {14'd0, rsp_valid, busy}, 16'd0);
    endtask

    initial begin
        int   g;
        int   last_g;
        int   cyc;
        logic drop;
        int   order [4];
        exp_t x;

        do_reset();
        chk("rst_busy",     {15'd0, busy},        16'd0);
        chk("rst_ready",    {14'd0, req_ready},   16'd0);
        chk("rst_rsp",      {14'd0, rsp_valid},   16'd0);
        chk("rst_strobes",  {14'd0, stk_push, stk_pop}, 16'd0);
        chk("rst_data_in",  {12'd0, stk_data_in}, 16'd0);

        do_op("push_a",   0, 1'b1, 4'hA, 1'b0, 4'h0);
        do_op("pop_a",    1, 1'b0, 4'h0, 1'b0, 4'hA);
        do_op("pop_empty", 0, 1'b0, 4'h0, 1'b1, 4'h0);

        // Both requesters held: req0 pushes 5, req1 pops it back.
        do_reset();
        order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
        req_valid = 2'b11;
        req_op    = 2'b01;
        req_data  = 8'h05;
        #1;
        g = 0; last_g = 0; drop = 1'b0;
        for (cyc = 0; cyc < 40 && (g < 4 || exp_q.size() != 0); cyc++) begin
            if (drop) req_valid = 2'b00;
            #1;
            if (rsp_valid != 2'b00) check_resp("rr");
            if (req_ready != 2'b00) begin
                chk("rr_grant", {14'd0, req_ready}, {14'd0, oh(order[g])});
                if (g > 0) chk("rr_spacing", 16'(cyc - last_g), 16'd3);
                last_g = cyc;
                x.idx  = order[g];
                x.err  = 1'b0;
                x.data = (order[g] == 1) ? 4'h5 : 4'h0;
                exp_q.push_back(x);
                g++;
                if (g == 4) drop = 1'b1;
            end
            tick();
        end
        chk("rr_grants", 16'(g), 16'd4);
        chk("rr_drain",  16'(exp_q.size()), 16'd0);
        req_valid = 2'b00;
        exp_q.delete();

        do_reset();
        do_op("d2_push1", 0, 1'b1, 4'h1, 1'b0, 4'h0);
        do_op("d2_push2", 1, 1'b1, 4'h2, 1'b0, 4'h0);
        do_op("d2_push3", 0, 1'b1, 4'h3, 1'b1, 4'h0);
        do_op("d2_pop",   1, 1'b0, 4'h0, 1'b0, 4'h2);
`ifdef STACK_ARBITER_STATS_EN
        chk("stat_push", stat_push, 16'd2);
        chk("stat_pop",  stat_pop,  16'd1);
        chk("stat_err",  stat_err,  16'd1);
`endif

        // Reset in ISSUE aborts the push and the stack is cleared with it.
        req_valid = 2'b01;
        req_op    = 2'b01;
        req_data  = 8'h07;
        #1;
        chk("ab_grant", {14'd0, req_ready}, 16'd1);
        tick();
        req_valid = 2'b00;
        chk("ab_issue", {15'd0, busy}, 16'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_busy",  {15'd0, busy},      16'd0);
        chk("ab_rsp0",  {14'd0, rsp_valid}, 16'd0);
        chk("ab_empty", {15'd0, stk_empty}, 16'd1);
        tick();
        chk("ab_rsp1",  {14'd0, rsp_valid}, 16'd0);
        tick();
        chk("ab_rsp2",  {14'd0, rsp_valid, busy}, 16'd0);
`ifdef STACK_ARBITER_STATS_EN
        chk("ab_stat", stat_push | stat_pop | stat_err, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be WIDTH, default 4, data width; NREQ, default 2, number of requesters (legal 2..8).
REQ-003 Ports SHALL be: clk  in  1  clock, all logic on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req_valid  in  NREQ  per-requester request; held with req_op/req_data until req_ready.
REQ-006 req_op  in  NREQ  per-requester operation; 1=push, 0=pop.
REQ-007 req_data  in  NREQ*WIDTH  push data; slice [i*WIDTH +: WIDTH] belongs to requester i.
REQ-008 req_ready  out  NREQ  one-hot accept strobe, one cycle.
REQ-009 rsp_valid  out  NREQ  one-hot completion strobe, one cycle.
REQ-010 rsp_err  out  1  completion was rejected; valid with rsp_valid.
REQ-011 rsp_data  out  WIDTH  popped data; valid with rsp_valid.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 stk_push, stk_pop  out  1 each  strobes to the stack.
REQ-014 stk_data_in  out  WIDTH  push data to the stack.
REQ-015 stk_data_out  in  WIDTH  stack read data, valid only in the cycle stk_pop=1.
REQ-016 stk_empty, stk_full  in  1 each  registered stack flags.

Function
REQ-017 FSM SHALL have states IDLE, ISSUE, RESP; transitions IDLE->ISSUE on any req_valid, ISSUE->RESP always, RESP->IDLE always.
REQ-018 In IDLE with any req_valid, winner = first set req_valid bit searching upward from rr_ptr with wrap modulo NREQ; req_ready[winner]=1 combinationally that cycle (T); winner index, op, data latched at T.
REQ-019 In ISSUE (T+1): push with stk_full=0 -> stk_push=1, stk_data_in=latched data; pop with stk_empty=0 -> stk_pop=1, stk_data_out captured into rsp register.
REQ-020 In ISSUE, push with stk_full=1 or pop with stk_empty=0 false (empty=1) -> no strobe, error flag set.
REQ-021 In RESP (T+2): rsp_valid[winner]=1, rsp_err=error flag, rsp_data=captured data (0 for push or error); rr_ptr <= (winner+1) mod NREQ.
REQ-022 stk_push and stk_pop SHALL never both be 1 and SHALL be 0 outside ISSUE; stk_data_in SHALL be 0 when stk_push=0.
REQ-023 Throughput SHALL be one operation per 3 cycles; accept-to-response latency exactly 2 cycles; stack flags thus always settled at ISSUE.
REQ-024 req_valid deasserted before grant SHALL be ignored; requests arriving in ISSUE/RESP wait (req_ready=0).
REQ-025 req_ready, rsp_valid SHALL be 0 outside IDLE and RESP respectively.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, rr_ptr=0, error flag=0, latched data=0; all outputs 0 next cycle.
REQ-027 Reset in ISSUE or RESP SHALL abort the operation with no rsp_valid; the stack SHALL be reset by the same rst.

Configuration
REQ-028 Macro STACK_ARBITER_STATS_EN defined: adds outputs stat_push, stat_pop, stat_err (16 bits each), counting successful pushes, successful pops and errors in RESP, saturating at 0xFFFF, cleared by rst.
REQ-029 Macro undefined: stat ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-030 Reset, req0 push 0xA -> req_ready[0] at T, stk_push=1/stk_data_in=0xA at T+1, rsp_valid[0]=1, rsp_err=0, rsp_data=0 at T+2.
REQ-031 Then req1 pop -> stk_pop=1 at T+1, rsp_valid[1]=1, rsp_data=0xA, rsp_err=0 at T+2.
REQ-032 After reset, req0 and req1 both held valid for 4 grants -> grant order 0,1,0,1; one grant per 3 cycles.
REQ-033 Pop on empty stack -> stk_pop never 1, rsp_err=1, rsp_data=0.
REQ-034 Stack DEPTH=2: push 1, push 2, push 3 -> third: no stk_push, rsp_err=1; then pop -> rsp_data=2.
REQ-035 rst during ISSUE -> no rsp_valid, busy=0 next cycle; with STACK_ARBITER_STATS_EN, REQ-034 sequence -> stat_push=2, stat_pop=1, stat_err=1.
